// File: rtl/encrypt_pkg.sv
// Shared definitions for the message-encryption engine.
//   state_e      : controller states
//   *_ADDR       : fixed data-memory locations of the run parameters
//   OUT_BASE     : first ciphertext byte address
//   PRE_MIN/MAX  : preamble clamp limits
//   tap_sel()    : maps the pattern selector byte to a 7-bit LFSR tap mask
package encrypt_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

  localparam int unsigned MEM_DEPTH = 256;
  localparam int unsigned MSG_LEN   = 64;

  localparam logic [7:0] PRE_ADDR  = 8'd61;
  localparam logic [7:0] PTRN_ADDR = 8'd62;
  localparam logic [7:0] SEED_ADDR = 8'd63;
  localparam logic [7:0] OUT_BASE  = 8'd64;
  localparam logic [7:0] PRE_MIN   = 8'd10;
  localparam logic [7:0] PRE_MAX   = 8'd26;

  // Entry 8 is reachable only when the low nibble is exactly 8; every other
  // selector uses its low three bits.
  function automatic logic [6:0] tap_sel(input logic [7:0] sel);
    logic [3:0] idx;
    idx = (sel[3:0] == 4'd8) ? 4'd8 : {1'b0, sel[2:0]};
    case (idx)
      4'd0:    tap_sel = 7'h60;
      4'd1:    tap_sel = 7'h48;
      4'd2:    tap_sel = 7'h78;
      4'd3:    tap_sel = 7'h72;
      4'd4:    tap_sel = 7'h6A;
      4'd5:    tap_sel = 7'h69;
      4'd6:    tap_sel = 7'h5C;
      4'd7:    tap_sel = 7'h7E;
      default: tap_sel = 7'h7B;
    endcase
  endfunction

endpackage

// File: rtl/data_mem.sv
// Byte-wide data memory: combinational read, synchronous write, no reset.
//   clk_i   : write clock
//   raddr_i : read address,  rdata_o : read data (combinational)
//   we_i    : write enable,  waddr_i / wdata_i : write address / data
module data_mem #(
  parameter int unsigned Depth = 256
) (
  input  logic       clk_i,
  input  logic [7:0] raddr_i,
  output logic [7:0] rdata_o,
  input  logic       we_i,
  input  logic [7:0] waddr_i,
  input  logic [7:0] wdata_i
);

  logic [7:0] Core [Depth];

  assign rdata_o = Core[raddr_i];

  always_ff @(posedge clk_i) begin
    if (we_i) Core[waddr_i] <= wdata_i;
  end

endmodule

// File: rtl/top_level.sv
// Message-encryption engine. Reads preamble length, tap selector and seed
// from memory, then writes 64 parity-tagged LFSR-encrypted bytes to
// Core[64..127] and raises Ack.
//   Clk   : rising-edge clock
//   Reset : asynchronous active-low reset
//   Start : arm with 1, launch when sampled 0 while armed
//   Ack   : registered done flag
module top_level
  import encrypt_pkg::*;
(
  input  logic Clk,
  input  logic Reset,
  input  logic Start,
  output logic Ack
);

  state_e     state_q;
  logic       armed_q;
  logic       ack_q;
  logic [5:0] cnt_q;    // LOAD step in [1:0], byte index i during RUN
  logic [7:0] pre_q;
  logic [6:0] taps_q;
  logic [6:0] lfsr_q;

  logic [7:0] raddr, rdata;
  logic       we;
  logic [7:0] waddr, wdata;
  logic       in_pre;
  logic [7:0] ptxt, c_raw;
  logic [6:0] lfsr_d, seed_d;
  logic [7:0] pre_d;

  data_mem #(
    .Depth(MEM_DEPTH)
  ) DM (
    .clk_i  (Clk),
    .raddr_i(raddr),
    .rdata_o(rdata),
    .we_i   (we),
    .waddr_i(waddr),
    .wdata_i(wdata)
  );

  always_comb begin
    in_pre = {2'b00, cnt_q} < pre_q;
    unique case (state_q)
      LOAD:    raddr = PRE_ADDR + {6'd0, cnt_q[1:0]};
      // Only meaningful when i >= pre; the result is then at most 53.
      RUN:     raddr = {2'b00, cnt_q} - pre_q;
      default: raddr = 8'd0;
    endcase

    ptxt  = in_pre ? 8'h20 : rdata;
    c_raw = ptxt ^ {1'b0, lfsr_q};
    wdata = {^c_raw[6:0], c_raw[6:0]};
    we    = (state_q == RUN);
    waddr = OUT_BASE + {2'b00, cnt_q};

    lfsr_d = {lfsr_q[5:0], ^(lfsr_q & taps_q)};
    seed_d = (rdata[6:0] == 7'd0) ? 7'h01 : rdata[6:0];
    if (rdata < PRE_MIN)      pre_d = PRE_MIN;
    else if (rdata > PRE_MAX) pre_d = PRE_MAX;
    else                      pre_d = rdata;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      armed_q <= 1'b0;
      ack_q   <= 1'b0;
      cnt_q   <= 6'd0;
      pre_q   <= 8'd0;
      taps_q  <= 7'd0;
      lfsr_q  <= 7'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          ack_q <= 1'b0;
          if (Start) begin
            armed_q <= 1'b1;
          end else if (armed_q) begin
            armed_q <= 1'b0;
            cnt_q   <= 6'd0;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          case (cnt_q[1:0])
            2'd0:    pre_q  <= pre_d;
            2'd1:    taps_q <= tap_sel(rdata);
            default: lfsr_q <= seed_d;
          endcase
          if (cnt_q[1:0] == 2'd2) begin
            cnt_q   <= 6'd0;
            state_q <= RUN;
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end
        RUN: begin
          lfsr_q <= lfsr_d;
          cnt_q  <= cnt_q + 6'd1;
          if (cnt_q == 6'(MSG_LEN - 1)) begin
            ack_q   <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (Start) begin
            ack_q   <= 1'b0;
            armed_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Ack = ack_q;

endmodule

// File: tb/tb_top_level.sv
module tb_top_level;
  import encrypt_pkg::*;

  logic Clk = 1'b0;
  logic Reset;
  logic Start;
  logic Ack;

  int checks = 0;
  int errors = 0;
  int cyc;

  logic [7:0] pt     [61];
  logic [7:0] exp_ct [64];
  logic [7:0] rsv    [128];

  top_level dut (
    .Clk  (Clk),
    .Reset(Reset),
    .Start(Start),
    .Ack  (Ack)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] tb_taps(input logic [7:0] sel);
    if (sel[3:0] == 4'h8) return 7'h7B;
    case (sel[2:0])
      3'd0: return 7'h60;
      3'd1: return 7'h48;
      3'd2: return 7'h78;
      3'd3: return 7'h72;
      3'd4: return 7'h6A;
      3'd5: return 7'h69;
      3'd6: return 7'h5C;
      default: return 7'h7E;
    endcase
  endfunction

  task automatic model(input logic [7:0] pre_raw, input logic [7:0] sel, input logic [7:0] seed);
    int pre;
    logic [6:0] l, t;
    logic [7:0] p, c;
    pre = (pre_raw < 10) ? 10 : ((pre_raw > 26) ? 26 : int'(pre_raw));
    l = seed[6:0];
    if (l == 7'd0) l = 7'd1;
    t = tb_taps(sel);
    for (int i = 0; i < 64; i++) begin
      p = (i < pre) ? 8'h20 : pt[i - pre];
      c = p ^ {1'b0, l};
      c[7] = ^c[6:0];
      exp_ct[i] = c;
      l = {l[5:0], ^(l & t)};
    end
  endtask

  task automatic load(input string s, input logic [7:0] pre_raw, input logic [7:0] sel,
                      input logic [7:0] seed);
    for (int k = 0; k < 61; k++) begin
      pt[k] = (k < s.len()) ? s[k] : 8'h20;
      dut.DM.Core[k] = pt[k];
    end
    dut.DM.Core[61] = pre_raw;
    dut.DM.Core[62] = sel;
    dut.DM.Core[63] = seed;
    for (int k = 64; k < 128; k++) dut.DM.Core[k] = 8'h00;
    model(pre_raw, sel, seed);
  endtask

  // Arm, launch, and count rising edges from the launch edge until Ack.
  task automatic do_run(input string tag, output int n);
    @(negedge Clk) Start = 1'b1;
    @(negedge Clk);
    check({tag, " ack_low_when_armed"}, 32'(Ack), 32'd0);
    Start = 1'b0;
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge Clk);
      n++;
      @(negedge Clk);
      if (Ack) break;
    end
  endtask

  task automatic check_out(input string tag);
    int mism = 0;
    int rmism = 0;
    for (int i = 0; i < 64; i++) if (dut.DM.Core[64 + i] !== exp_ct[i]) mism++;
    for (int k = 0; k < 128; k++) if (dut.DM.Core[128 + k] !== rsv[k]) rmism++;
    check({tag, " bytes_mismatched"}, 32'(mism), 32'd0);
    check({tag, " reserved_changed"}, 32'(rmism), 32'd0);
  endtask

  initial begin
    Reset = 1'b0;
    Start = 1'b0;
    for (int k = 0; k < 128; k++) begin
      rsv[k] = 8'(k) ^ 8'hA5;
      dut.DM.Core[128 + k] = rsv[k];
    end
    repeat (3) @(negedge Clk);
    check("reset ack", 32'(Ack), 32'd0);
    check("reset state", 32'(dut.state_q), 32'(IDLE));
    check("reset armed", 32'(dut.armed_q), 32'd0);
    Reset = 1'b1;

    // Run 1: seed 1, taps 0x60, pre 10
    load("Mr. Watson, come here. I want to see you.", 8'd10, 8'h00, 8'h01);
    do_run("run1", cyc);
    check("run1 latency", 32'(cyc), 32'd68);
    check("run1 ack", 32'(Ack), 32'd1);
    check("run1 core64", 32'(dut.DM.Core[64]), 32'h21);
    check("run1 core65", 32'(dut.DM.Core[65]), 32'h22);
    check_out("run1");

    // Start held low in DONE: no rerun
    repeat (5) @(negedge Clk);
    check("hold ack", 32'(Ack), 32'd1);
    check("hold state", 32'(dut.state_q), 32'(DONE));

    // Run 2: sel 0x08 -> taps 0x7B, pre 5 clamps to 10
    load("Hello, world!", 8'd5, 8'h08, 8'h35);
    do_run("run2", cyc);
    check("run2 latency", 32'(cyc), 32'd68);
    check("run2 taps", 32'(dut.taps_q), 32'h7B);
    check("run2 pre", 32'(dut.pre_q), 32'd10);
    check_out("run2");

    // Run 3: sel 0x0D -> taps 0x69, pre 30 clamps to 26, seed 0 -> 1
    load("The quick brown fox jumps over the lazy dog 0123456789", 8'd30, 8'h0D, 8'h00);
    do_run("run3", cyc);
    check("run3 latency", 32'(cyc), 32'd68);
    check("run3 taps", 32'(dut.taps_q), 32'h69);
    check("run3 pre", 32'(dut.pre_q), 32'd26);
    check("run3 lfsr_seed_core64", 32'(dut.DM.Core[64]), 32'h21);
    check_out("run3");

    // Run 4: reset mid-RUN, then a full rerun
    load("Abort and retry", 8'd12, 8'h03, 8'h5A);
    @(negedge Clk) Start = 1'b1;
    @(negedge Clk) Start = 1'b0;
    repeat (20) @(negedge Clk);
    Reset = 1'b0;
    #1;
    check("abort ack", 32'(Ack), 32'd0);
    check("abort state", 32'(dut.state_q), 32'(IDLE));
    check("abort partial core64", 32'(dut.DM.Core[64]), 32'(exp_ct[0]));
    @(negedge Clk) Reset = 1'b1;
    do_run("run4", cyc);
    check("run4 latency", 32'(cyc), 32'd68);
    check_out("run4");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
